// File: rtl/rsa_pkg.sv
// rsa_pkg -- shared definitions for the RSA datapath blocks.
//   DATA_W      : width of message, modulus and ciphertext
//   EXP_W       : width of the public exponent
//   state_t     : control states of the encryption sequencer
//   ENC_LATENCY : edges from the accepting start edge to the finish pulse
package rsa_pkg;

  localparam int DATA_W      = 16;
  localparam int EXP_W       = 8;
  localparam int K_W         = $clog2(EXP_W);
  localparam int CNT_W       = $clog2(DATA_W);
  localparam int ENC_LATENCY = 1 + DATA_W * (1 + 2 * EXP_W);

  localparam logic [DATA_W-1:0] N_MIN   = DATA_W'(2);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MULR   = 3'd2,
    MULB   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/rsa_mod_mult_serial.sv
// rsa_mod_mult_serial -- bit-serial interleaved modular multiplier.
// Computes p = a*b mod n in DATA_W cycles, scanning a MSB-first; requires b < n.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   go       : hold high for the whole multiply; phases may run back to back
//   a, b, n  : operands, held stable by the caller while go is high
//   done     : high during the cycle whose edge performs the final step
//   p        : result of the current step; equals a*b mod n while done is high
module rsa_mod_mult_serial
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] n,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] acc_in_s;
  logic [DATA_W:0]   dbl_s;
  logic [DATA_W-1:0] red1_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   n_ext_s;

  // One interleaved step: double, reduce, conditionally add b, reduce.
  always_comb begin
    n_ext_s = {1'b0, n};
    // The counter sits at its top value at the start of every multiply,
    // so the accumulator is taken as zero there without a separate clear cycle.
    if (cnt_r == CNT_TOP) begin
      acc_in_s = {DATA_W{1'b0}};
    end else begin
      acc_in_s = acc_r;
    end
    dbl_s  = {acc_in_s, 1'b0};
    red1_s = DATA_W'((dbl_s >= n_ext_s) ? (dbl_s - n_ext_s) : dbl_s);
    if (a[cnt_r]) begin
      sum_s = {1'b0, red1_s} + {1'b0, b};
    end else begin
      sum_s = {1'b0, red1_s};
    end
    p    = DATA_W'((sum_s >= n_ext_s) ? (sum_s - n_ext_s) : sum_s);
    done = go && (cnt_r == {CNT_W{1'b0}});
  end

  // Accumulator and bit counter; the counter wraps so phases chain seamlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_TOP;
      acc_r <= {DATA_W{1'b0}};
    end else if (go) begin
      cnt_r <= cnt_r - CNT_W'(1);
      acc_r <= p;
    end else begin
      cnt_r <= CNT_TOP;
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/rsa_encrypt_core.sv
// rsa_encrypt_core -- RSA public-key operation C = M^e mod n.
// Right-to-left square-and-multiply; every exponent bit costs one multiply
// into the result (committed only when the bit is set) and one squaring,
// so the run time does not depend on the exponent value.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   Input          : plaintext M (any value, reduced mod n internally)
//   encryptionKey  : public exponent e
//   n              : modulus
//   start          : request, sampled only in IDLE
//   Output         : ciphertext, registered, held between operations
//   finish         : one-cycle pulse when Output is updated
//   busy           : high while the exponentiation is running
//   err            : registered, set with finish when n < 2
module rsa_encrypt_core
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Input,
  input  logic [EXP_W-1:0]  encryptionKey,
  input  logic [DATA_W-1:0] n,
  input  logic              start,
  output logic [DATA_W-1:0] Output,
  output logic              finish,
  output logic              busy,
  output logic              err
);

  state_t            state_r;
  state_t            state_nx_s;
  logic [DATA_W-1:0] base_r;
  logic [DATA_W-1:0] result_r;
  logic [DATA_W-1:0] n_r;
  logic [DATA_W-1:0] out_r;
  logic [EXP_W-1:0]  e_r;
  logic [K_W-1:0]    k_r;
  logic              finish_r;
  logic              busy_r;
  logic              err_r;
  logic              accept_s;
  logic              go_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_a_s;
  logic [DATA_W-1:0] mul_b_s;
  logic [DATA_W-1:0] mul_p_s;

  assign Output = out_r;
  assign finish = finish_r;
  assign busy   = busy_r;
  assign err    = err_r;

  // The finish cycle is the tail of DONE, so a start coinciding with it is dropped.
  assign accept_s = start && !finish_r;

  rsa_mod_mult_serial u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (go_s),
    .a    (mul_a_s),
    .b    (mul_b_s),
    .n    (n_r),
    .done (mul_done_s),
    .p    (mul_p_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and multiplier operand selection.
  always_comb begin
    state_nx_s = state_r;
    go_s       = 1'b0;
    mul_a_s    = {DATA_W{1'b0}};
    mul_b_s    = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (n < N_MIN) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = REDUCE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      REDUCE: begin
        // M * 1 mod n reduces a message that may exceed the modulus.
        go_s    = 1'b1;
        mul_a_s = base_r;
        mul_b_s = DATA_W'(1);
        if (mul_done_s) begin
          state_nx_s = MULR;
        end else begin
          state_nx_s = REDUCE;
        end
      end
      MULR: begin
        go_s    = 1'b1;
        mul_a_s = result_r;
        mul_b_s = base_r;
        if (mul_done_s) begin
          state_nx_s = MULB;
        end else begin
          state_nx_s = MULR;
        end
      end
      MULB: begin
        go_s    = 1'b1;
        mul_a_s = base_r;
        mul_b_s = base_r;
        if (mul_done_s) begin
          if (k_r == K_W'(EXP_W - 1)) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = MULR;
          end
        end else begin
          state_nx_s = MULB;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand latching, result/base updates and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= {DATA_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
      n_r      <= {DATA_W{1'b0}};
      e_r      <= {EXP_W{1'b0}};
      k_r      <= {K_W{1'b0}};
      out_r    <= {DATA_W{1'b0}};
      finish_r <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      finish_r <= (state_r == DONE);
      busy_r   <= (state_nx_s == REDUCE) || (state_nx_s == MULR) || (state_nx_s == MULB);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            base_r   <= Input;
            e_r      <= encryptionKey;
            n_r      <= n;
            result_r <= DATA_W'(1);
            k_r      <= {K_W{1'b0}};
          end
        end
        REDUCE: begin
          if (mul_done_s) begin
            base_r <= mul_p_s;
          end
        end
        MULR: begin
          if (mul_done_s && e_r[k_r]) begin
            result_r <= mul_p_s;
          end
        end
        MULB: begin
          if (mul_done_s) begin
            base_r <= mul_p_s;
            k_r    <= k_r + K_W'(1);
          end
        end
        DONE: begin
          if (n_r < N_MIN) begin
            out_r <= {DATA_W{1'b0}};
            err_r <= 1'b1;
          end else begin
            out_r <= result_r;
            err_r <= 1'b0;
          end
        end
        default: begin
          base_r <= base_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_encrypt_core.sv
// tb_rsa_encrypt_core -- self-checking bench for rsa_encrypt_core.
// Expected ciphertexts come from a plain repeated-multiplication model of
// M^e mod n; latency is the fixed constant-time figure for an 8-bit exponent.
module tb_rsa_encrypt_core;

  localparam int LAT = 273;  // 1 + 16*(1 + 2*8)

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_m;
  logic [7:0]  key;
  logic [15:0] n_v;
  logic [15:0] out_c;
  logic        finish;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  rsa_encrypt_core dut (
    .clk           (clk),
    .rst           (rst),
    .Input         (in_m),
    .encryptionKey (key),
    .n             (n_v),
    .start         (start),
    .Output        (out_c),
    .finish        (finish),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: M^e mod n by repeated multiplication.
  function automatic longint unsigned ref_pow(longint unsigned m, longint unsigned e,
                                              longint unsigned nn);
    longint unsigned r;
    if (nn < 2) return 0;
    r = 1;
    for (longint unsigned i = 0; i < e; i++) r = (r * (m % nn)) % nn;
    return r;
  endfunction

  function automatic int gcd(int x, int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full operation with latency, busy, result, err and pulse-width checks.
  task automatic run_op(input logic [15:0] m, input logic [7:0] e, input logic [15:0] nn,
                        input string tag, input bit start_on_finish);
    int          lat;
    int          busy_bad;
    int          exp_lat;
    logic [15:0] exp_out;
    exp_out = 16'(ref_pow(m, e, nn));
    exp_lat = (nn < 2) ? 1 : LAT;
    in_m = m; key = e; n_v = nn; start = 1'b1;
    tick;
    start = 1'b0;
    // Inputs must have been latched; scramble them for the rest of the run.
    in_m = 16'($urandom); key = 8'($urandom); n_v = 16'($urandom);
    lat = 0;
    busy_bad = 0;
    for (int j = 1; j <= 400; j++) begin
      tick;
      if (finish === 1'b1) begin
        lat = j;
        break;
      end
      if (j <= exp_lat - 2 && busy !== 1'b1) busy_bad++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_output"}, out_c, exp_out);
    check({tag, "_err"}, err, (nn < 2) ? 1 : 0);
    if (nn >= 2) check({tag, "_busy_low_cycles"}, busy_bad, 0);
    if (start_on_finish) begin
      start = 1'b1; in_m = 16'd5; key = 8'd7; n_v = 16'd3551;
    end
    tick;
    start = 1'b0;
    check({tag, "_finish_width"}, finish, 0);
    if (start_on_finish) begin
      check({tag, "_start_at_finish_busy"}, busy, 0);
      tick;
      check({tag, "_start_at_finish_busy2"}, busy, 0);
    end
  endtask

  initial begin
    int          lat;
    int          fin_cnt;
    logic [15:0] m;
    logic [7:0]  e;
    logic [15:0] nn;
    int          d;

    rst = 1'b1; start = 1'b0; in_m = 16'd0; key = 8'd0; n_v = 16'd0;
    repeat (3) tick;
    check("reset_output", out_c, 0);
    check("reset_finish", finish, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    tick;

    // Directed vectors.
    run_op(16'd11, 8'd5, 16'd3551, "ex_11_5", 1'b0);
    check("ex_11_5_value", out_c, 1256);
    run_op(16'd2, 8'd3, 16'd15, "ex_2_3_15", 1'b0);
    run_op(16'd3562, 8'd5, 16'd3551, "m_above_n", 1'b0);
    check("m_above_n_value", out_c, 1256);
    run_op(16'd11, 8'd0, 16'd3551, "e_zero", 1'b0);
    run_op(16'd0, 8'd255, 16'd3551, "m_zero", 1'b0);
    run_op(16'd1234, 8'd77, 16'd1, "n_one", 1'b0);
    run_op(16'd99, 8'd3, 16'd0, "n_zero", 1'b0);
    run_op(16'd11, 8'd5, 16'd3551, "err_clear", 1'b1);
    run_op(16'd65535, 8'd255, 16'd65535, "max_operands", 1'b0);
    run_op(16'd65535, 8'd255, 16'd65521, "max_m_prime_n", 1'b0);

    // start re-pulsed mid-operation is ignored.
    in_m = 16'd11; key = 8'd5; n_v = 16'd3551; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    for (int j = 1; j <= 400; j++) begin
      if (j == 100) begin
        start = 1'b1; in_m = 16'd7; key = 8'd3; n_v = 16'd77;
      end else begin
        start = 1'b0;
      end
      tick;
      if (finish === 1'b1) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
    check("restart_ignored_latency", lat, LAT);
    check("restart_ignored_output", out_c, 1256);
    tick;

    // Reset in the middle of a run aborts without a finish pulse.
    in_m = 16'd2; key = 8'd3; n_v = 16'd15; start = 1'b1;
    tick;
    start = 1'b0;
    fin_cnt = 0;
    for (int j = 1; j < 150; j++) begin
      tick;
      if (finish === 1'b1) fin_cnt++;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_output", out_c, 0);
    check("midrst_finish", finish, 0);
    for (int j = 0; j < 300; j++) begin
      tick;
      if (finish !== 1'b0 || busy !== 1'b0) fin_cnt++;
    end
    check("midrst_no_activity", fin_cnt, 0);

    // Random sweep over the 67*53 modulus with exponents coprime to phi=3432.
    for (int i = 0; i < 6; i++) begin
      m = 16'($urandom_range(0, 3550));
      do e = 8'($urandom_range(1, 255)); while (gcd(int'(e), 3432) != 1);
      run_op(m, e, 16'd3551, "sweep_3551", 1'b0);
      d = 0;
      for (int k = 1; k < 3432; k++) begin
        if ((int'(e) * k) % 3432 == 1) begin
          d = k;
          break;
        end
      end
      check("sweep_decrypt", 32'(ref_pow(out_c, d, 3551)), m);
    end

    // Random moduli and full-range messages.
    for (int i = 0; i < 4; i++) begin
      nn = 16'($urandom_range(2, 65535));
      m  = 16'($urandom);
      e  = 8'($urandom_range(0, 255));
      run_op(m, e, nn, "sweep_rand_n", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_encrypt_core.md
Name: rsa_encrypt_core

Overview:
Public-key (encryption) side of the RSA datapath, the counterpart of the decryption path in Main. It computes C = M^e mod n for a 16-bit message, an 8-bit public exponent and a 16-bit modulus. It uses right-to-left square-and-multiply over a bit-serial interleaved modular multiplier. A start pulse begins the operation, and finish is a one-cycle pulse, so the block drops in beside the existing key-generation and decryption units.

Parameters:
DATA_W, 16, width of message, modulus and ciphertext
EXP_W, 8, width of public exponent (encryptionKey)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
Input  input  DATA_W  plaintext M; any value, not required to be < n
encryptionKey  input  EXP_W  public exponent e
n  input  DATA_W  modulus (p*q)
start  input  1  operation request; sampled only in IDLE
Output  output  DATA_W  ciphertext C, registered
finish  output  1  one-cycle pulse when Output is updated
busy  output  1  high from the cycle after start is accepted until finish
err  output  1  registered; high with finish when n < 2

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge. Output=0, finish=0, busy=0, err=0, state=IDLE, all internal registers cleared.
- Reset mid-operation: abort to IDLE on that edge. No finish pulse. Output=0.
- IDLE: on the edge that samples start=1, latch Input, encryptionKey and n into internal registers. Later input changes are ignored.
  - If the latched n < 2: go to DONE and set err=1.
  - Otherwise go to REDUCE with acc=0 and bit counter=15.
- start while busy=1, or while in DONE: ignored.
- Modular multiply modmul(a,b), b<n, 16 cycles, MSB-first over a:
  - each cycle, acc = 2*acc; if acc >= n, subtract n;
  - then, if a[i]=1, acc = acc + b; if acc >= n, subtract n.
  - Intermediates are 17 bits; at most one subtraction per step.
- REDUCE (16 cycles): base = modmul(M, 1) = M mod n. Set result = 1, exponent bit index k = 0.
- Per exponent bit k = 0..EXP_W-1, LSB first:
  - MULR (16 cycles): tmp = modmul(result, base). Commit result = tmp only if e[k]=1. The multiply always runs, giving constant time.
  - MULB (16 cycles): base = modmul(base, base).
  - After k = EXP_W-1, go to DONE.
- DONE (one cycle): Output <= result, or 0 if err. finish=1 for exactly this cycle. busy=0. Next state IDLE.
- Latency: with start sampled at edge t, finish is high after edge t+273, i.e. 1 + 16*(1 + 2*EXP_W) edges. For n < 2, finish is high after edge t+1.
- Between operations, Output and err hold their values until the next DONE or reset.
- e = 0 gives C = 1 for n ≥ 2. M = 0 gives C = 0 when e > 0.
- finish and a new start in the same cycle: that start is ignored, because the block is in DONE. start is accepted from the following IDLE cycle.

Decomposition:
- Shared package rsa_pkg holds:
  - DATA_W and EXP_W;
  - the state enum {IDLE, REDUCE, MULR, MULB, DONE};
  - the constant ENC_LATENCY = 273.
- One sub-module: rsa_mod_mult_serial.
  - Interface: clk, rst, go, a, b, n, done, p.
  - Behaviour: 16-cycle bit-serial interleaved multiply.
  - Shared with the decryption path later, where it is widened for decryptionKey.

Test Plan:
- Input=11, encryptionKey=5, n=3551 (67*53), start pulse -> Output=1256, err=0, finish exactly 273 cycles after start, busy high throughout.
- Input=2, e=3, n=15 -> Output=8. Then Input=3562 (= n+11), e=5, n=3551 -> Output=1256, confirming reduction of M ≥ n.
- e=0, Input=11, n=3551 -> Output=1. Input=0, e=255, n=3551 -> Output=0.
- n=1, any Input/e -> finish 1 cycle after start, err=1, Output=0. The next run with n=3551 clears err.
- start re-pulsed at cycle 100 with different inputs -> ignored, Output=1256 at cycle 273. rst at cycle 150 of a second run -> busy=0, Output=0, no finish pulse.
- Sweep: random M < n and e coprime with 3432, n=3551 -> compare against a software model of pow(M,e,n). The decryption unit with d recovers M.
